// File: rtl/add_seq_pkg.sv
// Shared state encoding and sizing helper for the sequential chunked adder.
package add_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index counter width: clog2(n), never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry adder built from full-adder cells.
module adder_slice #(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    always_comb begin
        logic c;
        sum = '0;
        c   = cin;
        for (int unsigned i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/chunked_add_seq.sv
// Multi-cycle wide adder: one shared SLICE_W-bit slice walks the operands
// over NSLICE cycles, carrying between slices in a register.
module chunked_add_seq
    import add_seq_pkg::*;
#(
    parameter int unsigned OP_W    = 12,
    parameter int unsigned SLICE_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic            cin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] sum,
    output logic            cout,
    output logic            busy
);

    localparam int unsigned NSLICE = (SLICE_W < 1) ? 1 : OP_W / SLICE_W;
    localparam int unsigned IDX_W  = idx_w(NSLICE);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NSLICE - 1);

    if (SLICE_W < 1 || (OP_W % SLICE_W) != 0) begin : g_bad_params
        $error("chunked_add_seq: OP_W must be a non-zero multiple of SLICE_W");
    end

    state_t             state, nxt;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [OP_W-1:0]    a_reg, b_reg, sum_reg;
    logic               cout_reg;
    logic [SLICE_W-1:0] a_sl, b_sl, s_sl;
    logic               c_sl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: if (in_valid)   nxt = ST_RUN;
            ST_RUN:  if (idx == LAST) nxt = ST_DONE;
            ST_DONE: if (out_ready)  nxt = ST_IDLE;
            default:                 nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state == ST_RUN) || (state == ST_DONE);
        sum       = sum_reg;
        cout      = cout_reg;
    end

    // Constant-index mux avoids a variable part-select on the operand regs.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) begin
                a_sl = a_reg[i*SLICE_W +: SLICE_W];
                b_sl = b_reg[i*SLICE_W +: SLICE_W];
            end
        end
    end

    adder_slice #(.W(SLICE_W)) u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .sum  (s_sl),
        .cout (c_sl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                ST_RUN: begin
                    for (int unsigned i = 0; i < NSLICE; i++) begin
                        if (idx == IDX_W'(i)) sum_reg[i*SLICE_W +: SLICE_W] <= s_sl;
                    end
                    carry <= c_sl;
                    if (idx == LAST) cout_reg <= c_sl;
                    else             idx      <= idx + 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        carry <= 1'b0;
                        idx   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_add_seq.sv
// Directed and random checks for chunked_add_seq at OP_W=12, SLICE_W=3.
module tb_chunked_add_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] a = '0;
    logic [11:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] sum;
    logic        cout;
    logic        busy;

    int errors = 0;
    int checks = 0;

    chunked_add_seq #(.OP_W(12), .SLICE_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One transaction: wait for in_ready, accept, count cycles to out_valid,
    // stall the consumer, then capture and consume the result.
    task automatic do_op(input logic [11:0] ta, input logic [11:0] tb_, input logic tc,
                         input int stall, output logic [11:0] rs, output logic rc,
                         output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
        end
        rs = sum; rc = cout;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [11:0] rs, hold_sum;
    logic        rc, hold_cout;
    int          lat;
    logic [11:0] ra, rb;
    logic        rcin;
    logic [12:0] gold;

    logic [11:0] bb_a [3] = '{12'h0FF, 12'hABC, 12'h800};
    logic [11:0] bb_b [3] = '{12'h001, 12'h544, 12'h800};
    logic        bb_c [3] = '{1'b0, 1'b1, 1'b0};
    logic [12:0] bb_e [3] = '{13'h0100, 13'h1001, 13'h1000};
    int          acc_cyc [3];

    initial begin
        #2;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_cout",      32'(cout),      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(12'hFFF, 12'h001, 1'b0, 0, rs, rc, lat);
        check("ripple_lat",  32'(lat), 32'd4);
        check("ripple_sum",  32'(rs),  32'h000);
        check("ripple_cout", 32'(rc),  32'd1);

        do_op(12'h5A5, 12'h25A, 1'b1, 0, rs, rc, lat);
        check("cin_lat",  32'(lat), 32'd4);
        check("cin_sum",  32'(rs),  32'h800);
        check("cin_cout", 32'(rc),  32'd0);

        // Backpressure: 0x321 + 0xCDE + 1 = 0x1000
        a = 12'h321; b = 12'hCDE; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        check("bp_valid", 32'(out_valid), 32'd1);
        hold_sum = sum; hold_cout = cout;
        check("bp_sum0", 32'(hold_sum), 32'h000);
        check("bp_cout0", 32'(hold_cout), 32'd1);
        a = 12'h111; b = 12'h111; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_ready", 32'(in_ready),  32'd0);
            check("bp_hold_sum",   32'(sum),       32'h000);
            check("bp_hold_cout",  32'(cout),      32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_idle_ready", 32'(in_ready), 32'd1);
        check("bp_idle_busy",  32'(busy),     32'd0);
        @(posedge clk); #1;
        check("bp_no_accept",  32'(busy),     32'd0);

        // Reset mid-op at idx=2
        a = 12'h123; b = 12'h456; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready),  32'd1);
        check("mid_rst_sum",   32'(sum),       32'd0);
        check("mid_rst_busy",  32'(busy),      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(12'h123, 12'h456, 1'b0, 1, rs, rc, lat);
        check("post_rst_sum",  32'(rs), 32'h579);
        check("post_rst_cout", 32'(rc), 32'd0);

        // Back-to-back with in_valid and out_ready held high
        begin
            int k, r, cyc;
            k = 0; r = 0; cyc = 0;
            out_ready = 1'b1;
            while (r < 3 && cyc < 60) begin
                if (in_ready) begin
                    if (k < 3) begin
                        a = bb_a[k]; b = bb_b[k]; cin = bb_c[k];
                        in_valid = 1'b1;
                        acc_cyc[k] = cyc;
                        k++;
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                if (out_valid) begin
                    check("b2b_result", 32'({cout, sum}), 32'(bb_e[r]));
                    r++;
                end
                @(posedge clk); #1;
                cyc++;
            end
            in_valid = 1'b0;
            out_ready = 1'b0;
            check("b2b_count", 32'(r), 32'd3);
            check("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
            check("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
        end

        for (int i = 0; i < 200; i++) begin
            ra = 12'($urandom); rb = 12'($urandom); rcin = 1'($urandom);
            gold = 13'(ra) + 13'(rb) + 13'(rcin);
            do_op(ra, rb, rcin, int'($urandom_range(0, 3)), rs, rc, lat);
            check("rand_lat", 32'(lat), 32'd4);
            check("rand_result", 32'({rc, rs}), 32'(gold));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
